gray_wptr_full: RTL and testbench

GRAY_WPTR_FULL -- requirements
Module: gray_wptr_full

---
 rtl/gray_wptr_full_if.sv | 49 ++++
 rtl/gray_wptr_full.sv | 90 +++++++++
 tb/tb_gray_wptr_full.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/gray_wptr_full_if.sv
// ---------------------------------------------------------------------------
// gray_wptr_full_if
//   Bundles the write-side FIFO pointer signals between the write-pointer /
//   full-flag block and the logic around it (producer, RAM, read domain).
//
//   Signals:
//     wr_req   producer write request
//     rd_gray  read-domain Gray pointer (asynchronous to the write clock)
//     wr_addr  RAM write address (low bits of the binary write pointer)
//     wr_gray  registered Gray write pointer, exported to the read domain
//     wr_ack   one-cycle pulse: a write was accepted on the previous edge
//     full     registered full flag
//     wr_used  registered, pessimistic write-side fill level
//
//   Modports:
//     master   the pointer block itself (drives the status outputs)
//     slave    the surrounding logic (drives wr_req and rd_gray)
// ---------------------------------------------------------------------------
interface gray_wptr_full_if #(
   parameter int ADDR_WIDTH = 4
);
   logic                  wr_req;
   logic [ADDR_WIDTH:0]   rd_gray;
   logic [ADDR_WIDTH-1:0] wr_addr;
   logic [ADDR_WIDTH:0]   wr_gray;
   logic                  wr_ack;
   logic                  full;
   logic [ADDR_WIDTH:0]   wr_used;

   modport master (
      input  wr_req,
      input  rd_gray,
      output wr_addr,
      output wr_gray,
      output wr_ack,
      output full,
      output wr_used
   );

   modport slave (
      output wr_req,
      output rd_gray,
      input  wr_addr,
      input  wr_gray,
      input  wr_ack,
      input  full,
      input  wr_used
   );
endinterface

// File: rtl/gray_wptr_full.sv
// ---------------------------------------------------------------------------
// gray_wptr_full
//   Write-side pointer and full-flag generator for an asynchronous FIFO.
//   Keeps a binary write pointer one bit wider than the RAM address, exports
//   it as a registered Gray code, synchronizes the read-domain Gray pointer
//   through two flops and derives a registered full flag and a pessimistic
//   fill level from it.
//
//   Parameters:
//     ADDR_WIDTH  FIFO address width (depth 2**ADDR_WIDTH); must be >= 2
//
//   Ports:
//     clock   write-domain clock, rising edge
//     reset   asynchronous active-high reset; release must be synchronous
//             to clock (handled by the integrating logic)
//     bus     gray_wptr_full_if.master (wr_req, rd_gray in;
//             wr_addr, wr_gray, wr_ack, full, wr_used out)
// ---------------------------------------------------------------------------
module gray_wptr_full #(
   parameter int ADDR_WIDTH = 4
) (
   input  logic              clock,
   input  logic              reset,
   gray_wptr_full_if.master  bus
);
   localparam int PW = ADDR_WIDTH + 1;

   logic [PW-1:0] wbin_reg;
   logic [PW-1:0] wgray_reg;
   logic [PW-1:0] rd_gray_s1_reg;
   logic [PW-1:0] rd_gray_s_reg;
   logic [PW-1:0] rd_bin_reg;
   logic [PW-1:0] wr_used_reg;
   logic          wr_ack_reg;
   logic          full_reg;

   logic          accept;
   logic [PW-1:0] wbin_next;
   logic [PW-1:0] wgray_next;
   logic [PW-1:0] rd_bin_dec;
   logic [PW-1:0] full_match;
   logic          full_next;

   // A write is taken only against the registered full of this cycle, so a
   // request that coincides with the full release is still rejected.
   assign accept     = bus.wr_req & ~full_reg;
   assign wbin_next  = wbin_reg + {{ADDR_WIDTH{1'b0}}, accept};
   assign wgray_next = (wbin_next >> 1) ^ wbin_next;

   // Gray-to-binary: each binary bit is the XOR of all Gray bits at and
   // above it, which avoids a bit-to-bit combinational chain.
   for (genvar gi = 0; gi < PW; gi++) begin : g_gray_dec
      assign rd_bin_dec[gi] = ^rd_gray_s_reg[PW-1:gi];
   end

   // Full when the write pointer is exactly one lap ahead of the read
   // pointer; in Gray code that is the top two bits inverted, rest equal.
   assign full_match = {~rd_gray_s_reg[PW-1:PW-2], rd_gray_s_reg[PW-3:0]};
   assign full_next  = (wgray_next == full_match);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         wbin_reg       <= '0;
         wgray_reg      <= '0;
         rd_gray_s1_reg <= '0;
         rd_gray_s_reg  <= '0;
         rd_bin_reg     <= '0;
         wr_used_reg    <= '0;
         wr_ack_reg     <= 1'b0;
         full_reg       <= 1'b0;
      end else begin
         wbin_reg       <= wbin_next;
         wgray_reg      <= wgray_next;
         rd_gray_s1_reg <= bus.rd_gray;
         rd_gray_s_reg  <= rd_gray_s1_reg;
         rd_bin_reg     <= rd_bin_dec;
         // rd_bin_reg lags the synchronized pointer by a cycle, so this can
         // only over-report the fill level, never under-report it.
         wr_used_reg    <= wbin_next - rd_bin_reg;
         wr_ack_reg     <= accept;
         full_reg       <= full_next;
      end
   end

   assign bus.wr_addr = wbin_reg[ADDR_WIDTH-1:0];
   assign bus.wr_gray = wgray_reg;
   assign bus.wr_ack  = wr_ack_reg;
   assign bus.full    = full_reg;
   assign bus.wr_used = wr_used_reg;
endmodule

// File: tb/tb_gray_wptr_full.sv
// ---------------------------------------------------------------------------
// tb_gray_wptr_full
//   Self-checking bench for gray_wptr_full with ADDR_WIDTH=2 (depth 4,
//   3-bit pointers). A vector table covers fill, full release and the
//   reject-at-release boundary; hand sequences cover reset and wrap-around.
//   Expected outputs are queued when a transaction is driven and compared
//   after the following clock edge.
// ---------------------------------------------------------------------------
module tb_gray_wptr_full;
   localparam int AW = 2;

   typedef struct {
      logic [AW-1:0] addr;
      logic [AW:0]   gray;
      logic          ack;
      logic          full;
      logic [AW:0]   used;
   } exp_t;

   typedef struct {
      logic        req;
      logic [AW:0] rdg;
      exp_t        e;
   } vec_t;

   logic clock;
   logic reset;
   int   n_checks = 0;
   int   n_err    = 0;
   int   n_txn    = 0;
   exp_t sb_q[$];
   vec_t vecs[14];
   logic [AW:0] gray_seq[8];
   logic [AW:0] prev_gray;

   gray_wptr_full_if #(.ADDR_WIDTH(AW)) bus ();

   gray_wptr_full #(.ADDR_WIDTH(AW)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_addr"}, 32'(bus.wr_addr), 32'd0);
      chk({tag, "_gray"}, 32'(bus.wr_gray), 32'd0);
      chk({tag, "_ack"},  32'(bus.wr_ack),  32'd0);
      chk({tag, "_full"}, 32'(bus.full),    32'd0);
      chk({tag, "_used"}, 32'(bus.wr_used), 32'd0);
   endtask

   // One transaction: drive at the falling edge, compare after the rising edge.
   task automatic step(input string tag, input logic req, input logic [AW:0] rdg, input exp_t e);
      exp_t got;
      @(negedge clock);
      bus.wr_req  = req;
      bus.rd_gray = rdg;
      sb_q.push_back(e);
      @(posedge clock);
      #1;
      got = sb_q.pop_front();
      n_txn++;
      chk({tag, "_addr"}, 32'(bus.wr_addr), 32'(got.addr));
      chk({tag, "_gray"}, 32'(bus.wr_gray), 32'(got.gray));
      chk({tag, "_ack"},  32'(bus.wr_ack),  32'(got.ack));
      chk({tag, "_full"}, 32'(bus.full),    32'(got.full));
      chk({tag, "_used"}, 32'(bus.wr_used), 32'(got.used));
      $display("txn %0d %s: req=%0b rd_gray=%03b -> addr=%02b gray=%03b ack=%0b full=%0b used=%0d",
               n_txn, tag, req, rdg, bus.wr_addr, bus.wr_gray, bus.wr_ack, bus.full, bus.wr_used);
   endtask

   task automatic do_reset();
      @(negedge clock);
      reset       = 1'b1;
      bus.wr_req  = 1'b0;
      bus.rd_gray = '0;
      @(negedge clock);
      reset = 1'b0;
   endtask

   initial begin
      // {req, rd_gray, {addr, gray, ack, full, used}}
      // Fill with the reader parked at 0.
      vecs[0]  = '{1'b1, 3'b000, '{2'b01, 3'b001, 1'b1, 1'b0, 3'd1}};
      vecs[1]  = '{1'b1, 3'b000, '{2'b10, 3'b011, 1'b1, 1'b0, 3'd2}};
      vecs[2]  = '{1'b1, 3'b000, '{2'b11, 3'b010, 1'b1, 1'b0, 3'd3}};
      vecs[3]  = '{1'b1, 3'b000, '{2'b00, 3'b110, 1'b1, 1'b1, 3'd4}};
      vecs[4]  = '{1'b1, 3'b000, '{2'b00, 3'b110, 1'b0, 1'b1, 3'd4}};
      // Reader advances to 1: full holds two edges, drops on the third,
      // fill level reaches 3 on the fourth.
      vecs[5]  = '{1'b0, 3'b001, '{2'b00, 3'b110, 1'b0, 1'b1, 3'd4}};
      vecs[6]  = '{1'b0, 3'b001, '{2'b00, 3'b110, 1'b0, 1'b1, 3'd4}};
      vecs[7]  = '{1'b0, 3'b001, '{2'b00, 3'b110, 1'b0, 1'b0, 3'd4}};
      vecs[8]  = '{1'b0, 3'b001, '{2'b00, 3'b110, 1'b0, 1'b0, 3'd3}};
      // Refill the freed slot: full again.
      vecs[9]  = '{1'b1, 3'b001, '{2'b01, 3'b111, 1'b1, 1'b1, 3'd4}};
      // Reader to 2 with a request held: rejected through the release
      // cycle, accepted the cycle after.
      vecs[10] = '{1'b1, 3'b011, '{2'b01, 3'b111, 1'b0, 1'b1, 3'd4}};
      vecs[11] = '{1'b1, 3'b011, '{2'b01, 3'b111, 1'b0, 1'b1, 3'd4}};
      vecs[12] = '{1'b1, 3'b011, '{2'b01, 3'b111, 1'b0, 1'b0, 3'd4}};
      vecs[13] = '{1'b1, 3'b011, '{2'b10, 3'b101, 1'b1, 1'b1, 3'd4}};

      gray_seq[0] = 3'b000; gray_seq[1] = 3'b001; gray_seq[2] = 3'b011; gray_seq[3] = 3'b010;
      gray_seq[4] = 3'b110; gray_seq[5] = 3'b111; gray_seq[6] = 3'b101; gray_seq[7] = 3'b100;

      reset       = 1'b1;
      bus.wr_req  = 1'b0;
      bus.rd_gray = '0;
      repeat (2) @(posedge clock);
      #1;
      chk_all_zero("reset_state");
      @(negedge clock);
      reset = 1'b0;

      for (int i = 0; i < 14; i++)
         step($sformatf("vec%0d", i), vecs[i].req, vecs[i].rdg, vecs[i].e);

      // Reset in the middle of operation after three accepts.
      do_reset();
      step("pre_rst1", 1'b1, 3'b000, '{2'b01, 3'b001, 1'b1, 1'b0, 3'd1});
      step("pre_rst2", 1'b1, 3'b000, '{2'b10, 3'b011, 1'b1, 1'b0, 3'd2});
      step("pre_rst3", 1'b1, 3'b000, '{2'b11, 3'b010, 1'b1, 1'b0, 3'd3});
      @(negedge clock);
      bus.wr_req = 1'b0;
      #1;
      reset = 1'b1;
      #1;
      chk_all_zero("mid_rst");
      @(negedge clock);
      reset = 1'b0;
      #1;
      chk("post_rst_addr", 32'(bus.wr_addr), 32'd0);
      step("post_rst", 1'b1, 3'b000, '{2'b01, 3'b001, 1'b1, 1'b0, 3'd1});

      // Wrap-around: the reader follows the writer as closely as it can,
      // so full never asserts while the pointer laps twice.
      do_reset();
      prev_gray = 3'b000;
      for (int k = 1; k <= 16; k++) begin
         exp_t e;
         e.addr = 2'(k % 4);
         e.gray = gray_seq[k % 8];
         e.ack  = 1'b1;
         e.full = 1'b0;
         e.used = (k < 4) ? 3'(k) : 3'd4;
         step($sformatf("wrap%0d", k), 1'b1, gray_seq[(k - 1) % 8], e);
         chk($sformatf("wrap%0d_onebit", k), 32'($countones(bus.wr_gray ^ prev_gray)), 32'd1);
         prev_gray = bus.wr_gray;
      end

      if (sb_q.size() != 0) begin
         n_checks++;
         n_err++;
         $display("FAIL scoreboard_drain: got %0d expected 0", sb_q.size());
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end
endmodule
